// File: rtl/mult_pkg.sv
// Shared definitions for the parametrised sequential multiplier.
// State encodings and width derivations used by the top and its tests.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_A_WIDTH = 8;
  localparam int DEF_B_WIDTH = 8;
  localparam int DEF_SLICE   = 4;

  function automatic int calc_steps(input int b_w, input int slice);
    return b_w / slice;
  endfunction

  function automatic int calc_p_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic int calc_cnt_w(input int steps);
    return $clog2(steps) + 1;
  endfunction

endpackage

// File: rtl/mult_slice_pp.sv
// Combinational A_WIDTH x SLICE partial product.
// Both operands are unsigned magnitudes.
module mult_slice_pp #(
  parameter int A_WIDTH = 8,
  parameter int SLICE   = 4
) (
  input  logic [A_WIDTH-1:0]       a_i,
  input  logic [SLICE-1:0]         b_i,
  output logic [A_WIDTH+SLICE-1:0] pp_o
);

  localparam int PP_W = A_WIDTH + SLICE;

  assign pp_o = PP_W'(a_i) * PP_W'(b_i);

endmodule

// File: rtl/seq_mult_param.sv
// Shift-add multiplier retiring SLICE multiplier bits per cycle.
// Signed mode multiplies magnitudes and fixes the sign on completion.
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH,
  parameter int SLICE   = DEF_SLICE
) (
  input  logic                       clk,
  input  logic                       reset_a,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [A_WIDTH-1:0]         dataa,
  input  logic [B_WIDTH-1:0]         datab,
  output logic                       busy,
  output logic                       done_flag,
  output logic [A_WIDTH+B_WIDTH-1:0] product_out
);

  localparam int STEPS   = calc_steps(B_WIDTH, SLICE);
  localparam int P_WIDTH = calc_p_width(A_WIDTH, B_WIDTH);
  localparam int CNT_W   = calc_cnt_w(STEPS);
  localparam int PP_W    = A_WIDTH + SLICE;

  if (B_WIDTH % SLICE != 0) begin : g_bad_slice
    $error("SLICE must divide B_WIDTH");
  end
  if (A_WIDTH < 2 || B_WIDTH < 2) begin : g_bad_width
    $error("operand widths must be at least 2");
  end

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [B_WIDTH-1:0] b_q, b_d;
  logic               sign_q, sign_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [P_WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;

  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;
  logic [PP_W-1:0]    pp;
  logic [P_WIDTH-1:0] pp_sh;

  assign a_mag = (signed_mode && dataa[A_WIDTH-1])
               ? A_WIDTH'(-dataa) : dataa;
  assign b_mag = (signed_mode && datab[B_WIDTH-1])
               ? B_WIDTH'(-datab) : datab;

  // b_q shifts right each step, so its low bits are the current slice
  mult_slice_pp #(
    .A_WIDTH (A_WIDTH),
    .SLICE   (SLICE)
  ) u_pp (
    .a_i  (a_q),
    .b_i  (b_q[SLICE-1:0]),
    .pp_o (pp)
  );

  assign pp_sh = P_WIDTH'(pp) << (int'(step_q) * SLICE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    step_d  = step_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_mag;
          b_d     = b_mag;
          sign_d  = signed_mode
                  & (dataa[A_WIDTH-1] ^ datab[B_WIDTH-1]);
          acc_d   = '0;
          step_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_q + pp_sh;
        b_d    = b_q >> SLICE;
        step_d = step_q + 1'b1;
        if (step_q == CNT_W'(STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        prod_d  = sign_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      step_q  <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done_flag   = done_q;
  assign product_out = prod_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: default 8x8/SLICE4
// instance plus a 16x16/SLICE1 instance.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        start0, sm0;
  logic [7:0]  a0, b0;
  logic        busy0, done0;
  logic [15:0] prod0;
  logic        start1, sm1;
  logic [15:0] a1, b1;
  logic        busy1, done1;
  logic [31:0] prod1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.A_WIDTH(8), .B_WIDTH(8), .SLICE(4)) dut0 (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start0),
    .signed_mode (sm0),
    .dataa       (a0),
    .datab       (b0),
    .busy        (busy0),
    .done_flag   (done0),
    .product_out (prod0)
  );

  seq_mult_param #(.A_WIDTH(16), .B_WIDTH(16), .SLICE(1)) dut1 (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start1),
    .signed_mode (sm1),
    .dataa       (a1),
    .datab       (b1),
    .busy        (busy1),
    .done_flag   (done1),
    .product_out (prod1)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op on dut0, then check latency and product
  task automatic op0(input logic [7:0] a, input logic [7:0] b,
                     input logic sm, input logic [15:0] exp,
                     input string name);
    int n;
    @(negedge clk);
    a0 = a; b0 = b; sm0 = sm; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'd3);
    chk({name, " product"}, 64'(prod0), 64'(exp));
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b,
                     input logic sm, input logic [31:0] exp,
                     input string name);
    int n;
    @(negedge clk);
    a1 = a; b1 = b; sm1 = sm; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'd17);
    chk({name, " product"}, 64'(prod1), 64'(exp));
  endtask

  vec_t vecs[10];

  initial begin
    int dones;
    vecs[0] = '{8'd10,  8'd20,  1'b0, 16'd200};
    vecs[1] = '{8'd100, 8'd200, 1'b0, 16'h4E20};
    vecs[2] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[3] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[4] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1};
    vecs[5] = '{8'h80,  8'h80,  1'b0, 16'h4000};
    vecs[6] = '{8'd0,   8'd77,  1'b0, 16'h0000};
    vecs[7] = '{8'd127, 8'h80,  1'b1, 16'hC080};
    vecs[8] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    vecs[9] = '{8'd0,   8'hFB,  1'b1, 16'h0000};

    reset_a = 1'b0;
    start0 = 1'b0; sm0 = 1'b0; a0 = '0; b0 = '0;
    start1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy0), 64'd0);
    chk("reset done", 64'(done0), 64'd0);
    chk("reset product", 64'(prod0), 64'd0);
    reset_a = 1'b1;

    // busy/done timing for 10*20
    @(negedge clk);
    a0 = 8'd10; b0 = 8'd20; sm0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("t1 busy k", 64'(busy0), 64'd1);
    @(negedge clk);
    chk("t1 busy k+1", 64'(busy0), 64'd1);
    @(negedge clk);
    chk("t1 busy k+2", 64'(busy0), 64'd1);
    chk("t1 done early", 64'(done0), 64'd0);
    @(negedge clk);
    chk("t1 busy k+3", 64'(busy0), 64'd0);
    chk("t1 done", 64'(done0), 64'd1);
    chk("t1 product", 64'(prod0), 64'd200);
    @(negedge clk);
    chk("t1 done pulse", 64'(done0), 64'd0);
    chk("t1 product held", 64'(prod0), 64'd200);

    for (int i = 0; i < 10; i++) begin
      op0(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp,
          $sformatf("vec%0d", i));
    end

    // start during DONE is ignored
    @(negedge clk);
    a0 = 8'd100; b0 = 8'd200; sm0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    a0 = 8'd3; b0 = 8'd3; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("t2 done", 64'(done0), 64'd1);
    chk("t2 product", 64'(prod0), 64'h4E20);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0) dones++;
    end
    chk("t2 no second done", 64'(dones), 64'd0);
    chk("t2 idle", 64'(busy0), 64'd0);

    // start mid-CALC is ignored
    @(negedge clk);
    a0 = 8'd10; b0 = 8'd20; start0 = 1'b1;
    @(negedge clk);
    a0 = 8'd7; b0 = 8'd7;
    @(negedge clk);
    start0 = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done0) dones++;
    end
    chk("t4 single done", 64'(dones), 64'd1);
    chk("t4 product", 64'(prod0), 64'd200);

    // async reset mid-CALC
    @(negedge clk);
    a0 = 8'd9; b0 = 8'd9; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    #2 reset_a = 1'b0;
    #1;
    chk("t5 busy", 64'(busy0), 64'd0);
    chk("t5 done", 64'(done0), 64'd0);
    chk("t5 product", 64'(prod0), 64'd0);
    @(negedge clk);
    reset_a = 1'b1;
    op0(8'd12, 8'd12, 1'b0, 16'd144, "t5 12x12");

    // 16x16, one bit per step
    op1(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "t6 unsigned");
    op1(16'h8000, 16'd2, 1'b1, 32'hFFFF0000, "t6 signed");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
